pcie_str_chan_mux: RTL and testbench
====================================

PCIE_STR_CHAN_MUX -- requirements
Module: pcie_str_chan_mux

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 4, number of user stream channels (1..8); CW = max(1, $clog2(NUM_CHAN)).
REQ-002 SHALL have parameter DATA_W, default 128, stream beat width in bits (power of two, >= 32).
REQ-003 SHALL have parameter LEN_W, default 32, DMA length width in bytes.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 65535, idle-beat cycles before abort.
REQ-005 SHALL have ports: i_pcie_clk in 1, the only clock; i_rst_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: i_s2u_en in 1, start pulse; i_s2u_chan in CW; i_s2u_len in LEN_W; i_s2u_valid in 1; o_s2u_ack out 1; i_s2u_data in DATA_W.
REQ-007 SHALL have ports: o_chan_wr_valid out NUM_CHAN; i_chan_wr_ack in NUM_CHAN; o_chan_wr_data out DATA_W, shared by all channels.
REQ-008 SHALL have ports: i_u2s_en in 1; i_u2s_chan in CW; i_u2s_len in LEN_W; o_u2s_valid out 1; i_u2s_ack in 1; o_u2s_data out DATA_W.
REQ-009 SHALL have ports: i_chan_rd_valid in NUM_CHAN; o_chan_rd_ack out NUM_CHAN; i_chan_rd_data in NUM_CHAN*DATA_W, channel c at bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have ports: o_intr_req out 1; i_intr_ack in 1; o_intr_status out 2*NUM_CHAN; o_timeout_err out 2; o_busy out 2 ([0] s2u, [1] u2s).

Function
REQ-011 SHALL run two independent direction engines (s2u, u2s), each FSM IDLE -> XFER -> DONE -> IDLE.
REQ-012 SHALL in IDLE, on en=1, latch chan and beats = ceil(len / (DATA_W/8)); go to XFER if beats>0, else to DONE.
REQ-013 SHALL ignore en in XFER or DONE; SHALL ignore en with chan >= NUM_CHAN (stays IDLE, no status).
REQ-014 SHALL complete a beat in any cycle where valid and ack are both high; zero-latency combinational forwarding of valid, ack and data.
REQ-015 SHALL in s2u XFER drive o_chan_wr_valid[sel] = i_s2u_valid, o_s2u_ack = i_chan_wr_ack[sel]; all other channel valids 0; o_chan_wr_data = i_s2u_data.
REQ-016 SHALL in u2s XFER drive o_u2s_valid = i_chan_rd_valid[sel], o_chan_rd_ack[sel] = i_u2s_ack, o_u2s_data = selected channel data; other acks 0.
REQ-017 SHALL hold all valids/acks low outside XFER, so beats beyond the programmed count are never accepted.
REQ-018 SHALL decrement the beat counter per beat; on the final beat go to DONE next cycle.
REQ-019 SHALL in DONE (one cycle) set status bit sel (s2u) or NUM_CHAN+sel (u2s), then return to IDLE.
REQ-020 SHALL assert o_intr_req registered, one cycle after any status bit becomes set; hold until i_intr_ack.
REQ-021 SHALL on i_intr_ack while o_intr_req=1 clear o_intr_status and o_timeout_err, drop o_intr_req next cycle; a DONE in the same cycle keeps its bit and re-raises o_intr_req next cycle.
REQ-022 SHALL drive o_busy[d] = 1 when engine d is not IDLE.

Reset
REQ-023 SHALL asynchronously on i_rst_n=0 force both FSMs to IDLE, counters 0, o_intr_req 0, o_intr_status 0, o_timeout_err 0, o_busy 0; all valid/ack outputs 0.
REQ-024 SHALL abort an in-flight transfer on reset with no status set; release is synchronous to i_pcie_clk.

Configuration
REQ-025 SHALL with PCIE_STR_CHAN_MUX_TIMEOUT_EN defined count consecutive XFER cycles without a beat, reset on each beat; reaching TIMEOUT_CYC goes to DONE, setting the status bit and o_timeout_err[d].
REQ-026 SHALL without PCIE_STR_CHAN_MUX_TIMEOUT_EN omit the counter, tie o_timeout_err to 0, and keep XFER indefinitely.

Structure
REQ-027 SHALL put FSM state encoding (IDLE, XFER, DONE) and direction index constants in a shared package pcie_str_pkg.
REQ-028 SHALL implement each direction as one instance of sub-module pcie_str_xfer_eng (FSM, beat counter, timeout); the top holds muxing and interrupt logic.

Verification
REQ-029 SHALL cover s2u: chan=2, len=64, DATA_W=128 -> 4 beats on o_chan_wr_valid[2] only, status bit 2 set, o_intr_req high next cycle.
REQ-030 SHALL cover u2s: chan=1, len=17 -> 2 beats from channel 1 data; 3rd valid not acked; status bit NUM_CHAN+1.
REQ-031 SHALL cover len=0 -> no beats, status bit set, and en during busy -> ignored, beat count unchanged.
REQ-032 SHALL cover concurrent s2u chan 0 and u2s chan 3 with random ack stalls -> both complete and both status bits set; ack coincident with a DONE -> bit kept, o_intr_req re-raised.
REQ-033 SHALL cover, with macro, TIMEOUT_CYC=16 and ack held low -> abort after 16 idle cycles, o_timeout_err[0]=1; without macro -> no abort.
REQ-034 SHALL cover i_rst_n pulled low mid-transfer -> all outputs 0 immediately, no status after release.

Source files
------------

// File: rtl/pcie_str_pkg.sv
// pcie_str_pkg
// Definitions shared by the PCIe stream channel multiplexer:
//   - xfer_state_e : direction-engine FSM encoding (IDLE, XFER, DONE)
//   - DIR_S2U/DIR_U2S : index of each direction in o_busy / o_timeout_err
//   - chan_w()     : channel-select width, never narrower than one bit
package pcie_str_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_e;

  localparam int DIR_S2U = 0;
  localparam int DIR_U2S = 1;
  localparam int NUM_DIR = 2;

  function automatic int chan_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/pcie_str_chan_mux_if.sv
// pcie_str_chan_mux_if
// Bundles every handshake/bus signal of pcie_str_chan_mux. Signal names are
// the block's port names, seen from the multiplexer (i_* into it, o_* out).
//   slave  : the multiplexer side
//   master : the environment side (host engine, user channels, irq controller)
// Parameters must match those of the pcie_str_chan_mux instance.
interface pcie_str_chan_mux_if #(
  parameter int NUM_CHAN = 4,
  parameter int DATA_W   = 128,
  parameter int LEN_W    = 32
) ();
  localparam int CW = pcie_str_pkg::chan_w(NUM_CHAN);

  // stream-to-user direction
  logic                       i_s2u_en;
  logic [CW-1:0]              i_s2u_chan;
  logic [LEN_W-1:0]           i_s2u_len;
  logic                       i_s2u_valid;
  logic                       o_s2u_ack;
  logic [DATA_W-1:0]          i_s2u_data;
  logic [NUM_CHAN-1:0]        o_chan_wr_valid;
  logic [NUM_CHAN-1:0]        i_chan_wr_ack;
  logic [DATA_W-1:0]          o_chan_wr_data;
  // user-to-stream direction
  logic                       i_u2s_en;
  logic [CW-1:0]              i_u2s_chan;
  logic [LEN_W-1:0]           i_u2s_len;
  logic                       o_u2s_valid;
  logic                       i_u2s_ack;
  logic [DATA_W-1:0]          o_u2s_data;
  logic [NUM_CHAN-1:0]        i_chan_rd_valid;
  logic [NUM_CHAN-1:0]        o_chan_rd_ack;
  logic [NUM_CHAN*DATA_W-1:0] i_chan_rd_data;
  // interrupt / status
  logic                       o_intr_req;
  logic                       i_intr_ack;
  logic [2*NUM_CHAN-1:0]      o_intr_status;
  logic [1:0]                 o_timeout_err;
  logic [1:0]                 o_busy;

  modport slave (
    input  i_s2u_en, i_s2u_chan, i_s2u_len, i_s2u_valid, i_s2u_data, i_chan_wr_ack,
    input  i_u2s_en, i_u2s_chan, i_u2s_len, i_u2s_ack, i_chan_rd_valid, i_chan_rd_data,
    input  i_intr_ack,
    output o_s2u_ack, o_chan_wr_valid, o_chan_wr_data,
    output o_u2s_valid, o_u2s_data, o_chan_rd_ack,
    output o_intr_req, o_intr_status, o_timeout_err, o_busy
  );

  modport master (
    output i_s2u_en, i_s2u_chan, i_s2u_len, i_s2u_valid, i_s2u_data, i_chan_wr_ack,
    output i_u2s_en, i_u2s_chan, i_u2s_len, i_u2s_ack, i_chan_rd_valid, i_chan_rd_data,
    output i_intr_ack,
    input  o_s2u_ack, o_chan_wr_valid, o_chan_wr_data,
    input  o_u2s_valid, o_u2s_data, o_chan_rd_ack,
    input  o_intr_req, o_intr_status, o_timeout_err, o_busy
  );
endinterface

// File: rtl/pcie_str_xfer_eng.sv
// pcie_str_xfer_eng
// One direction engine: IDLE -> XFER -> DONE -> IDLE.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : start pulse, honoured only in IDLE with a channel < NUM_CHAN
//   i_chan     : channel to latch on start
//   i_len      : transfer length in bytes, rounded up to whole beats
//   i_beat     : one beat completed this cycle (valid & ack, gated by XFER)
//   o_state    : current FSM state
//   o_sel      : latched channel
//   o_timeout  : in DONE, high when the transfer was ended by the idle timer
// Macro PCIE_STR_CHAN_MUX_TIMEOUT_EN adds the idle-beat timer; without it an
// XFER waits for its beats indefinitely and o_timeout stays 0.
module pcie_str_xfer_eng import pcie_str_pkg::*; #(
  parameter  int NUM_CHAN    = 4,
  parameter  int DATA_W      = 128,
  parameter  int LEN_W       = 32,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int CW          = chan_w(NUM_CHAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CW-1:0]    i_chan,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_beat,
  output xfer_state_e      o_state,
  output logic [CW-1:0]    o_sel,
  output logic             o_timeout
);
  localparam int BYTES      = DATA_W / 8;
  localparam int SHIFT      = $clog2(BYTES);
  localparam int CHAN_SPACE = 1 << CW;

  xfer_state_e             state_q, state_d;
  logic [CW-1:0]           sel_q, sel_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [LEN_W:0]          len_rnd_s;
  logic [LEN_W-1:0]        beats_s;
  logic [CHAN_SPACE-1:0]   chan_ok_s;

`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
  logic [31:0]             idle_q, idle_d;
  logic                    to_q, to_d;
`else
  logic                    unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC == 0);
`endif

  // One extra bit keeps the round-up from wrapping at the top of the length range.
  assign len_rnd_s = {1'b0, i_len} + (LEN_W+1)'(BYTES - 1);
  assign beats_s   = LEN_W'(len_rnd_s >> SHIFT);

  // Channel codes that map to a real channel; the rest are rejected at start.
  always_comb begin
    chan_ok_s = '0;
    for (int c = 0; c < CHAN_SPACE; c++) begin
      chan_ok_s[c] = (c < NUM_CHAN) ? 1'b1 : 1'b0;
    end
  end

  // Next-state logic for the FSM, beat counter and idle timer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
    idle_d  = idle_q;
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_en && chan_ok_s[i_chan]) begin
          sel_d   = i_chan;
          cnt_d   = beats_s;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
          idle_d  = 32'd0;
          to_d    = 1'b0;
`endif
          state_d = (beats_s != '0) ? ST_XFER : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (i_beat) begin
          cnt_d = cnt_q - LEN_W'(1);
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
          idle_d = 32'd0;
`endif
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
        else if (idle_q == 32'(TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
        end else begin
          idle_d  = idle_q + 32'd1;
        end
`else
        else begin
          state_d = ST_XFER;
        end
`endif
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and selected-channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
      idle_q  <= 32'd0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
      idle_q  <= idle_d;
      to_q    <= to_d;
`endif
    end
  end

  assign o_state = state_q;
  assign o_sel   = sel_q;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
  assign o_timeout = to_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: rtl/pcie_str_chan_mux.sv
// pcie_str_chan_mux
// Routes a PCIe DMA stream to/from one of NUM_CHAN user channels, one engine
// per direction, and raises an interrupt with per-channel completion status.
//   i_pcie_clk : the only clock
//   i_rst_n    : asynchronous active-low reset
//   bus        : pcie_str_chan_mux_if.slave -- s2u stream and channel write
//                ports, u2s stream and channel read ports, interrupt/status
// Valid, ack and data are forwarded combinationally while an engine is in
// XFER and are held low otherwise, so extra beats are never accepted.
// Macro PCIE_STR_CHAN_MUX_TIMEOUT_EN enables the per-direction idle-beat abort
// (reported in o_timeout_err); without it o_timeout_err stays 0.
module pcie_str_chan_mux import pcie_str_pkg::*; #(
  parameter int NUM_CHAN    = 4,
  parameter int DATA_W      = 128,
  parameter int LEN_W       = 32,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic               i_pcie_clk,
  input logic               i_rst_n,
  pcie_str_chan_mux_if.slave bus
);
  localparam int CW = chan_w(NUM_CHAN);

  xfer_state_e           s2u_state_s, u2s_state_s;
  logic [CW-1:0]         s2u_sel_s, u2s_sel_s;
  logic                  s2u_to_s, u2s_to_s;
  logic                  s2u_xfer_s, u2s_xfer_s;
  logic                  s2u_done_s, u2s_done_s;
  logic                  s2u_beat_s, u2s_beat_s;
  logic [NUM_CHAN-1:0]   wr_valid_s, rd_ack_s;
  logic                  s2u_ack_s, u2s_valid_s;
  logic [DATA_W-1:0]     wr_data_s, u2s_data_s;
  logic [2*NUM_CHAN-1:0] status_q, status_d;
  logic [1:0]            terr_q, terr_d;
  logic                  intr_q, intr_d;

  pcie_str_xfer_eng #(
    .NUM_CHAN(NUM_CHAN), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_s2u_eng (
    .clk(i_pcie_clk), .rst_n(i_rst_n),
    .i_en(bus.i_s2u_en), .i_chan(bus.i_s2u_chan), .i_len(bus.i_s2u_len),
    .i_beat(s2u_beat_s),
    .o_state(s2u_state_s), .o_sel(s2u_sel_s), .o_timeout(s2u_to_s)
  );

  pcie_str_xfer_eng #(
    .NUM_CHAN(NUM_CHAN), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_u2s_eng (
    .clk(i_pcie_clk), .rst_n(i_rst_n),
    .i_en(bus.i_u2s_en), .i_chan(bus.i_u2s_chan), .i_len(bus.i_u2s_len),
    .i_beat(u2s_beat_s),
    .o_state(u2s_state_s), .o_sel(u2s_sel_s), .o_timeout(u2s_to_s)
  );

  assign s2u_xfer_s = (s2u_state_s == ST_XFER);
  assign u2s_xfer_s = (u2s_state_s == ST_XFER);
  assign s2u_done_s = (s2u_state_s == ST_DONE);
  assign u2s_done_s = (u2s_state_s == ST_DONE);

  // Channel steering: only the selected channel sees the handshake, only in XFER.
  always_comb begin
    wr_valid_s  = '0;
    rd_ack_s    = '0;
    s2u_ack_s   = 1'b0;
    u2s_valid_s = 1'b0;
    u2s_data_s  = '0;
    wr_data_s   = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (s2u_xfer_s && (s2u_sel_s == CW'(c))) begin
        wr_valid_s[c] = bus.i_s2u_valid;
        s2u_ack_s     = bus.i_chan_wr_ack[c];
      end else begin
        wr_valid_s[c] = 1'b0;
      end
      if (u2s_xfer_s && (u2s_sel_s == CW'(c))) begin
        u2s_valid_s = bus.i_chan_rd_valid[c];
        rd_ack_s[c] = bus.i_u2s_ack;
        u2s_data_s  = bus.i_chan_rd_data[c*DATA_W +: DATA_W];
      end else begin
        rd_ack_s[c] = 1'b0;
      end
    end
    if (s2u_xfer_s) begin
      wr_data_s = bus.i_s2u_data;
    end else begin
      wr_data_s = '0;
    end
  end

  // Acks are already gated by XFER, so these are true beats only.
  assign s2u_beat_s = bus.i_s2u_valid & s2u_ack_s;
  assign u2s_beat_s = u2s_valid_s & bus.i_u2s_ack;

  // Status/interrupt next state. The ack-clear is applied before the DONE set,
  // so a completion in the ack cycle survives and re-raises the request.
  always_comb begin
    status_d = status_q;
    terr_d   = terr_q;
    if (bus.i_intr_ack && intr_q) begin
      status_d = '0;
      terr_d   = 2'b00;
    end else begin
      status_d = status_q;
      terr_d   = terr_q;
    end
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (s2u_done_s && (s2u_sel_s == CW'(c))) begin
        status_d[c] = 1'b1;
      end else begin
        status_d[c] = status_d[c];
      end
      if (u2s_done_s && (u2s_sel_s == CW'(c))) begin
        status_d[NUM_CHAN + c] = 1'b1;
      end else begin
        status_d[NUM_CHAN + c] = status_d[NUM_CHAN + c];
      end
    end
    if (s2u_done_s && s2u_to_s) begin
      terr_d[DIR_S2U] = 1'b1;
    end else begin
      terr_d[DIR_S2U] = terr_d[DIR_S2U];
    end
    if (u2s_done_s && u2s_to_s) begin
      terr_d[DIR_U2S] = 1'b1;
    end else begin
      terr_d[DIR_U2S] = terr_d[DIR_U2S];
    end
    // The request follows the registered status by one cycle and drops on ack.
    intr_d = (|status_q) && !(bus.i_intr_ack && intr_q);
  end

  // Status, timeout-error and interrupt-request registers.
  always_ff @(posedge i_pcie_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q <= '0;
      terr_q   <= 2'b00;
      intr_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      terr_q   <= terr_d;
      intr_q   <= intr_d;
    end
  end

  assign bus.o_chan_wr_valid = wr_valid_s;
  assign bus.o_s2u_ack       = s2u_ack_s;
  assign bus.o_chan_wr_data  = wr_data_s;
  assign bus.o_u2s_valid     = u2s_valid_s;
  assign bus.o_chan_rd_ack   = rd_ack_s;
  assign bus.o_u2s_data      = u2s_data_s;
  assign bus.o_intr_req      = intr_q;
  assign bus.o_intr_status   = status_q;
  assign bus.o_timeout_err   = terr_q;
  assign bus.o_busy          = {(u2s_state_s != ST_IDLE), (s2u_state_s != ST_IDLE)};

endmodule

// File: tb/tb_pcie_str_chan_mux.sv
// Bench for pcie_str_chan_mux: a table of single-direction transfers with
// random handshake stalls, random concurrent transfers, and hand-written
// sequences for busy-start, ack/DONE collision, idle timeout and reset.
module tb_pcie_str_chan_mux;
  localparam int NC = 4;
  localparam int DW = 128;
  localparam int LW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pcie_str_chan_mux_if #(.NUM_CHAN(NC), .DATA_W(DW), .LEN_W(LW)) bus ();

  pcie_str_chan_mux #(.NUM_CHAN(NC), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
    .i_pcie_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       dir;      // 0 = s2u, 1 = u2s
    int       chan;
    int       len;
    bit [7:0] exp_status;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nbeats(input int len);
    return (len + DW/8 - 1) / (DW/8);
  endfunction

  task automatic idle_inputs();
    bus.i_s2u_en = 1'b0; bus.i_s2u_chan = '0; bus.i_s2u_len = '0;
    bus.i_s2u_valid = 1'b0; bus.i_s2u_data = '0; bus.i_chan_wr_ack = '0;
    bus.i_u2s_en = 1'b0; bus.i_u2s_chan = '0; bus.i_u2s_len = '0;
    bus.i_u2s_ack = 1'b0; bus.i_chan_rd_valid = '0; bus.i_chan_rd_data = '0;
    bus.i_intr_ack = 1'b0;
  endtask

  task automatic all_high();
    bus.i_s2u_en = 1'b0; bus.i_u2s_en = 1'b0;
    bus.i_s2u_valid = 1'b1; bus.i_chan_wr_ack = '1;
    bus.i_u2s_ack = 1'b1; bus.i_chan_rd_valid = '1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_wr_valid"}, bus.o_chan_wr_valid, 0);
    chk({tag, "_s2u_ack"}, bus.o_s2u_ack, 0);
    chk({tag, "_u2s_valid"}, bus.o_u2s_valid, 0);
    chk({tag, "_rd_ack"}, bus.o_chan_rd_ack, 0);
  endtask

  task automatic clear_intr();
    @(negedge clk);
    idle_inputs();
    bus.i_intr_ack = 1'b1;
    #1 chk("intr_before_ack", bus.o_intr_req, 1);
    @(negedge clk);
    bus.i_intr_ack = 1'b0;
    #1;
    chk("intr_after_ack", bus.o_intr_req, 0);
    chk("status_after_ack", bus.o_intr_status, 0);
    chk("terr_after_ack", bus.o_timeout_err, 0);
  endtask

  // Start transfers, drive random handshakes and check forwarding against the
  // number of beats still owed by each direction.
  task automatic run_xfer(input bit do_s, input int s_chan, input int s_len,
                          input bit do_u, input int u_chan, input int u_len,
                          input int pct, input bit exact);
    int s_rem, u_rem, cyc, exp_n, n;
    bit s_on, u_on;
    logic [NC-1:0] exp_wr, exp_ra;
    logic [2*NC-1:0] exp_bit;
    s_rem = do_s ? nbeats(s_len) : 0;
    u_rem = do_u ? nbeats(u_len) : 0;
    exp_n = do_s ? s_rem : u_rem;
    exp_bit = do_s ? (8'h01 << s_chan) : (8'h01 << (NC + u_chan));
    cyc = 0;
    @(negedge clk);
    idle_inputs();
    bus.i_s2u_en = do_s; bus.i_s2u_chan = s_chan[1:0]; bus.i_s2u_len = s_len;
    bus.i_u2s_en = do_u; bus.i_u2s_chan = u_chan[1:0]; bus.i_u2s_len = u_len;
    do begin
      @(negedge clk);
      bus.i_s2u_en = 1'b0; bus.i_u2s_en = 1'b0;
      bus.i_s2u_valid = ($urandom_range(99) >= pct);
      bus.i_u2s_ack = ($urandom_range(99) >= pct);
      bus.i_s2u_data = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 0; c < NC; c++) begin
        bus.i_chan_wr_ack[c] = ($urandom_range(99) >= pct);
        bus.i_chan_rd_valid[c] = ($urandom_range(99) >= pct);
        bus.i_chan_rd_data[c*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      s_on = (s_rem > 0);
      u_on = (u_rem > 0);
      exp_wr = '0;
      exp_ra = '0;
      if (s_on && bus.i_s2u_valid) exp_wr[s_chan] = 1'b1;
      if (u_on && bus.i_u2s_ack) exp_ra[u_chan] = 1'b1;
      chk("wr_valid", bus.o_chan_wr_valid, exp_wr);
      chk("s2u_ack", bus.o_s2u_ack, s_on ? bus.i_chan_wr_ack[s_chan] : 1'b0);
      chk("u2s_valid", bus.o_u2s_valid, u_on ? bus.i_chan_rd_valid[u_chan] : 1'b0);
      chk("rd_ack", bus.o_chan_rd_ack, exp_ra);
      if (s_on) begin
        chk("wr_data", bus.o_chan_wr_data, bus.i_s2u_data);
        chk("busy_s2u", bus.o_busy[0], 1);
        if (bus.i_s2u_valid && bus.i_chan_wr_ack[s_chan]) s_rem--;
      end
      if (u_on) begin
        chk("u2s_data", bus.o_u2s_data, bus.i_chan_rd_data[u_chan*DW +: DW]);
        chk("busy_u2s", bus.o_busy[1], 1);
        if (bus.i_u2s_ack && bus.i_chan_rd_valid[u_chan]) u_rem--;
      end
      cyc++;
    end while ((s_rem > 0 || u_rem > 0) && cyc < 2000);
    if (cyc >= 2000) chk("xfer_cycle_bound", cyc, 0);
    if (exact) begin
      n = (exp_n == 0) ? 1 : 2;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        all_high();
        #1 check_quiet("post");
        if (k < n) begin
          chk("busy_in_done", bus.o_busy, do_s ? 2'b01 : 2'b10);
          chk("status_early", bus.o_intr_status, 0);
        end else begin
          chk("busy_after", bus.o_busy, 0);
          chk("status_set", bus.o_intr_status, exp_bit);
          chk("intr_not_yet", bus.o_intr_req, 0);
        end
      end
      @(negedge clk);
      #1;
      chk("intr_raised", bus.o_intr_req, 1);
      check_quiet("post2");
    end else begin
      repeat (4) begin
        @(negedge clk);
        all_high();
        #1 check_quiet("post");
      end
      chk("busy_after", bus.o_busy, 0);
    end
    idle_inputs();
  endtask

  initial begin
    vec_t vecs[7];
    int cnt, sc, uc, sl, ul;
    bit ds, du;
    logic [2*NC-1:0] exp_st;

    vecs[0] = '{1'b0, 2, 64,  8'h04};
    vecs[1] = '{1'b1, 1, 17,  8'h20};
    vecs[2] = '{1'b0, 0, 0,   8'h01};
    vecs[3] = '{1'b1, 3, 1,   8'h80};
    vecs[4] = '{1'b0, 3, 16,  8'h08};
    vecs[5] = '{1'b1, 0, 33,  8'h10};
    vecs[6] = '{1'b0, 1, 200, 8'h02};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_intr", bus.o_intr_req, 0);
    chk("rst_status", bus.o_intr_status, 0);
    chk("rst_terr", bus.o_timeout_err, 0);
    check_quiet("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // table of single-direction transfers
    foreach (vecs[i]) begin
      run_xfer(!vecs[i].dir, vecs[i].chan, vecs[i].len,
               vecs[i].dir, vecs[i].chan, vecs[i].len, 30, 1'b1);
      chk("vec_status", bus.o_intr_status, vecs[i].exp_status);
      clear_intr();
    end

    // start requests while busy are ignored
    @(negedge clk);
    bus.i_s2u_en = 1'b1; bus.i_s2u_chan = 2'd2; bus.i_s2u_len = 64;
    repeat (3) begin
      @(negedge clk);
      bus.i_s2u_chan = 2'd1; bus.i_s2u_len = 160;
      #1 chk("busy_en_quiet", bus.o_chan_wr_valid, 0);
    end
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      bus.i_s2u_en = 1'b0;
      bus.i_s2u_valid = 1'b1; bus.i_chan_wr_ack = '1;
      bus.i_s2u_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (bus.o_chan_wr_valid[2] && bus.o_s2u_ack) cnt++;
      chk("busy_en_chan1", bus.o_chan_wr_valid[1], 0);
    end
    chk("busy_en_beats", cnt, 4);
    chk("busy_en_status", bus.o_intr_status, 8'h04);
    clear_intr();

    // concurrent transfers with heavy stalls
    run_xfer(1'b1, 0, 96, 1'b1, 3, 80, 50, 1'b0);
    chk("conc_status", bus.o_intr_status, 8'h81);
    chk("conc_intr", bus.o_intr_req, 1);

    // interrupt ack in the same cycle as a DONE
    @(negedge clk);
    bus.i_s2u_en = 1'b1; bus.i_s2u_chan = 2'd1; bus.i_s2u_len = 0;
    @(negedge clk);
    bus.i_s2u_en = 1'b0;
    bus.i_intr_ack = 1'b1;
    #1 chk("coll_busy_done", bus.o_busy, 2'b01);
    @(negedge clk);
    bus.i_intr_ack = 1'b0;
    #1;
    chk("coll_status", bus.o_intr_status, 8'h02);
    chk("coll_intr_drop", bus.o_intr_req, 0);
    @(negedge clk);
    #1 chk("coll_intr_reraise", bus.o_intr_req, 1);
    clear_intr();

    // random concurrent transfers
    for (int r = 0; r < 6; r++) begin
      ds = 1'($urandom_range(1)); du = 1'($urandom_range(1));
      if (!ds && !du) ds = 1'b1;
      sc = $urandom_range(NC-1); uc = $urandom_range(NC-1);
      sl = $urandom_range(100); ul = $urandom_range(100);
      run_xfer(ds, sc, sl, du, uc, ul, $urandom_range(60), 1'b0);
      exp_st = '0;
      if (ds) exp_st[sc] = 1'b1;
      if (du) exp_st[NC + uc] = 1'b1;
      chk("rand_status", bus.o_intr_status, exp_st);
      clear_intr();
    end

    // idle-beat timeout: valid high, channel never acks
    @(negedge clk);
    bus.i_s2u_en = 1'b1; bus.i_s2u_chan = 2'd0; bus.i_s2u_len = 64;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      bus.i_s2u_en = 1'b0; bus.i_s2u_valid = 1'b1; bus.i_chan_wr_ack = '0;
    end
    #1 chk("to_busy17", bus.o_busy, 2'b01);
    @(negedge clk);
    #1;
`ifdef PCIE_STR_CHAN_MUX_TIMEOUT_EN
    chk("to_busy18", bus.o_busy, 2'b00);
    chk("to_status", bus.o_intr_status, 8'h01);
    chk("to_err", bus.o_timeout_err, 2'b01);
`else
    chk("to_busy18", bus.o_busy, 2'b01);
    chk("to_status", bus.o_intr_status, 8'h00);
    chk("to_err", bus.o_timeout_err, 2'b00);
    repeat (4) begin
      @(negedge clk);
      bus.i_chan_wr_ack = '1;
    end
    repeat (3) begin
      @(negedge clk);
      idle_inputs();
    end
    #1;
    chk("noto_status", bus.o_intr_status, 8'h01);
    chk("noto_err", bus.o_timeout_err, 2'b00);
`endif
    clear_intr();

    // reset in the middle of transfers, with an older status still pending
    run_xfer(1'b1, 3, 20, 1'b0, 0, 0, 20, 1'b0);
    @(negedge clk);
    bus.i_s2u_en = 1'b1; bus.i_s2u_chan = 2'd2; bus.i_s2u_len = 64;
    bus.i_u2s_en = 1'b1; bus.i_u2s_chan = 2'd1; bus.i_u2s_len = 64;
    @(negedge clk);
    all_high();
    @(negedge clk);
    #1;
    chk("pre_rst_wr", bus.o_chan_wr_valid, 4'b0100);
    chk("pre_rst_rd", bus.o_chan_rd_ack, 4'b0010);
    #1 rst_n = 1'b0;
    #1;
    check_quiet("mid_rst");
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_status", bus.o_intr_status, 0);
    chk("mid_rst_intr", bus.o_intr_req, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      all_high();
      #1 check_quiet("after_rst");
    end
    chk("after_rst_status", bus.o_intr_status, 0);
    chk("after_rst_intr", bus.o_intr_req, 0);
    chk("after_rst_busy", bus.o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
